fix_fetch: RTL and testbench
============================

FIX_FETCH -- requirements
Module: fix_fetch

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 8x8 fix tiles, 2 ROM reads per row, 2-entry output FIFO.
REQ-002 clk  in  1  system clock; all logic is on the rising edge.
REQ-003 rstn  in  1  reset; one clock, asynchronous and active-low.
REQ-004 cmd_valid  in  1  a row fetch command is offered.
REQ-005 cmd_ready  out  1  the command is accepted when cmd_valid && cmd_ready at a clock edge.
REQ-006 cmd_tile  in  8  fix tile index.
REQ-007 cmd_row  in  3  pixel row within the tile.
REQ-008 msreq  out  1  ROM read request; single-cycle pulse.
REQ-009 msaddr  out  17  ROM read address.
REQ-010 msack  in  1  ROM read acknowledge; msdata is valid in the same cycle.
REQ-011 msdata  in  16  ROM read data; only bits 0, 4, 8 and 12 are significant.
REQ-012 out_valid  out  1  FIFO head holds a fetched row.
REQ-013 out_ready  in  1  the head is popped when out_valid && out_ready at a clock edge.
REQ-014 out_data  out  8  fetched row bits.
REQ-015 out_tile  out  8  tile tag of the head entry.
REQ-016 out_row  out  3  row tag of the head entry.

Function
REQ-017 SHALL run an FSM with states IDLE, REQ0, WAIT0, REQ1, WAIT1, PUSH.
REQ-018 cmd_ready SHALL be 1 only when in IDLE with fifo_count + 0 < 2; a handshake latches tile/row and moves to REQ0.
REQ-019 REQ0 SHALL drive msreq=1 for exactly one cycle with msaddr = {4'b0, tile, 1'b0, 1'b0, row}; next state WAIT0.
REQ-020 WAIT0 SHALL hold msaddr stable and keep msreq=0 until msack=1; msack sampled in any other state SHALL be ignored.
REQ-021 On msack in WAIT0, SHALL capture nib0 = {msdata[0], msdata[4], msdata[8], msdata[12]} (msdata[0] as MSB); next state REQ1.
REQ-022 REQ1/WAIT1 SHALL behave as REQ0/WAIT0 with msaddr bit 4 = 1, capturing nib1; next state PUSH.
REQ-023 PUSH SHALL write {nib0, nib1} with tile/row tags into the FIFO in one cycle, then return to IDLE.
REQ-024 The minimum per-row latency SHALL be 6 cycles from command acceptance to out_valid, given msack one cycle after msreq.
REQ-025 The FIFO SHALL be 2 entries, first-word fall-through; out_* SHALL reflect the head entry combinationally from storage registers.
REQ-026 A push and pop in the same cycle SHALL leave the count unchanged; a pop with count 0 SHALL be impossible because out_valid=0.
REQ-027 PUSH SHALL never occur when the FIFO is full; this is guaranteed by the REQ-018 admission check, since fifo_count only decreases while a fetch is in flight.
REQ-028 Read and write pointers SHALL be 1 bit each, wrapping 1->0; the count SHALL be 2 bits (range 0..2).
REQ-029 msdata bits other than 0, 4, 8 and 12 SHALL have no effect on any output.
REQ-030 msack SHALL have no minimum or maximum latency requirement; the FSM waits indefinitely.

Reset
REQ-031 While rstn=0 (asserted asynchronously): state=IDLE, msreq=0, msaddr=0, fifo_count=0, pointers=0, out_valid=0, out_data=0, out_tile=0, out_row=0, cmd_ready=0.
REQ-032 cmd_ready SHALL become 1 on the first clock edge after rstn deasserts.
REQ-033 Reset asserted mid-fetch SHALL abandon the fetch and empty the FIFO; a late msack after reset SHALL be ignored.

Verification
REQ-034 Basic fetch: tile 0x12, row 5; ack one cycle after each request with msdata 0x1001 then 0x0110 -> msaddr 0x00245 then 0x00255, out_data=0x96, out_tile=0x12, out_row=5, out_valid on cycle 6.
REQ-035 Noise rejection: msdata 0xEEEF then 0xFFFE -> out_data=0x87 (only bits 0, 4, 8 and 12 matter).
REQ-036 Backpressure: out_ready=0, issue 3 commands -> 2 rows stored and cmd_ready=0; one pop -> cmd_ready=1 and the third row completes; rows emerge in command order.
REQ-037 Slow ROM: msack delayed 7 cycles -> msreq pulses exactly once per half and msaddr holds steady; a spurious msack in IDLE is ignored, with no FIFO change.
REQ-038 Reset in WAIT1, then rstn release -> all REQ-031 values hold; a subsequent fetch of tile 0xFF, row 7 -> msaddr 0x01FE7 then 0x01FF7.
REQ-039 Simultaneous push and pop with count 1 -> count stays 1, and the head advances to the new row.

Source files
------------

// File: rtl/fix_fetch.sv
// -----------------------------------------------------------------------------
// fix_fetch -- fetches one 8-pixel row of an 8x8 fix tile from a 16-bit ROM
// and queues it in a 2-entry first-word fall-through FIFO.
//
// Each row takes two ROM reads. Only bits 0, 4, 8 and 12 of a read word carry
// pixel data; they are packed MSB-first (bit 0 is the MSB) into a nibble. The
// first read (address bit 4 = 0) gives the upper nibble of the row, and the
// second read (address bit 4 = 1) gives the lower nibble.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   cmd_valid  row fetch command offered
//   cmd_ready  command accepted on cmd_valid && cmd_ready (registered)
//   cmd_tile   tile index (8 bits)
//   cmd_row    pixel row within the tile (3 bits)
//   msreq      ROM read request, one-cycle pulse (registered)
//   msaddr     ROM read address (17 bits, registered, held until the ack)
//   msack      ROM acknowledge; msdata is valid in the same cycle
//   msdata     ROM read data (16 bits)
//   out_valid  FIFO head holds a fetched row
//   out_ready  pops the head on out_valid && out_ready
//   out_data   fetched row bits
//   out_tile   tile tag of the head entry
//   out_row    row tag of the head entry
// -----------------------------------------------------------------------------
module fix_fetch (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_tile,
  input  logic [2:0]  cmd_row,
  output logic        msreq,
  output logic [16:0] msaddr,
  input  logic        msack,
  input  logic [15:0] msdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [7:0]  out_tile,
  output logic [2:0]  out_row
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    PUSH  = 3'd5
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] tile;
    logic [2:0] row;
  } entry_t;

  // ROM address layout: {4'b0, tile, half, 1'b0, row}.
  function automatic logic [16:0] rom_addr(input logic [7:0] tile,
                                           input logic [2:0] row,
                                           input logic       half);
    return {4'b0000, tile, half, 1'b0, row};
  endfunction

  // Pixel bits sit every fourth bit of the ROM word; bit 0 becomes the MSB.
  function automatic logic [3:0] pick_pixels(input logic [15:0] word);
    return {word[0], word[4], word[8], word[12]};
  endfunction

  state_t     state;
  logic [7:0] tile_q;
  logic [2:0] row_q;
  logic [3:0] nib0;
  logic [3:0] nib1;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       push;
  logic       pop;

  // The remaining msdata bits carry no pixel data and are deliberately dropped.
  logic unused_msdata;
  assign unused_msdata = ^{msdata[15:13], msdata[11:9], msdata[7:5], msdata[3:1]};

  assign push = (state == PUSH);
  assign pop  = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would infer a latch.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // First-word fall-through: the head is read straight from storage.
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr].data;
  assign out_tile  = mem[rd_ptr].tile;
  assign out_row   = mem[rd_ptr].row;

  // NOTE: the FIFO storage is reset because the head is visible on out_* and
  // must read as zero while in reset; a deeper buffer would skip this.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: {nib0, nib1}, tile: tile_q, row: row_q};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

  // Fetch sequencer. msreq, msaddr and cmd_ready are registered: each is
  // computed for the state being entered. cmd_ready is only raised for IDLE,
  // using the post-edge FIFO count, so a fetch is admitted only when its row
  // is guaranteed a free slot at PUSH (the count can only fall meanwhile).
  // NOTE: all state here is assigned with <= so every register sees the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      msreq     <= 1'b0;
      msaddr    <= '0;
      tile_q    <= '0;
      row_q     <= '0;
      nib0      <= '0;
      nib1      <= '0;
    end else begin
      msreq     <= 1'b0;
      cmd_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            tile_q <= cmd_tile;
            row_q  <= cmd_row;
            msaddr <= rom_addr(cmd_tile, cmd_row, 1'b0);
            msreq  <= 1'b1;
            state  <= REQ0;
          end else begin
            cmd_ready <= (count_next < 2'd2);
          end
        end
        REQ0: state <= WAIT0;
        WAIT0: begin
          if (msack) begin
            nib0   <= pick_pixels(msdata);
            msaddr <= rom_addr(tile_q, row_q, 1'b1);
            msreq  <= 1'b1;
            state  <= REQ1;
          end
        end
        REQ1: state <= WAIT1;
        WAIT1: begin
          if (msack) begin
            nib1  <= pick_pixels(msdata);
            state <= PUSH;
          end
        end
        PUSH: begin
          state     <= IDLE;
          cmd_ready <= (count_next < 2'd2);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_fetch.sv
// -----------------------------------------------------------------------------
// tb_fix_fetch -- directed self-checking bench for fix_fetch.
// Inputs change and outputs are sampled on the falling clock edge; the DUT
// acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_fix_fetch;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_tile;
  logic [2:0]  cmd_row;
  logic        msreq;
  logic [16:0] msaddr;
  logic        msack;
  logic [15:0] msdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_tile;
  logic [2:0]  out_row;

  int tests;
  int failed;

  fix_fetch dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_tile  (cmd_tile),
    .cmd_row   (cmd_row),
    .msreq     (msreq),
    .msaddr    (msaddr),
    .msack     (msack),
    .msdata    (msdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tile  (out_tile),
    .out_row   (out_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Drives one command and answers both ROM reads, acking 'dly' cycles after
  // the cycle following each msreq. Returns at the falling edge of the PUSH
  // cycle with the observed addresses, the number of msreq cycles seen and
  // whether msaddr held steady while waiting.
  task automatic run_fetch(input logic [7:0] t, input logic [2:0] r,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input int dly,
                           output logic [16:0] a0, output logic [16:0] a1,
                           output int nreq, output bit stable, output bit ok);
    logic [16:0] addr;
    int n;
    ok = 1'b1; nreq = 0; stable = 1'b1; a0 = '0; a1 = '0;
    cmd_tile = t; cmd_row = r; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin ok = 1'b0; cmd_valid = 1'b0; return; end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int h = 0; h < 2; h++) begin
      n = 0;
      while (msreq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin ok = 1'b0; return; end
      addr = msaddr;
      nreq++;
      repeat (dly + 1) begin
        @(negedge clk);
        if (msreq === 1'b1) nreq++;
        if (msaddr !== addr) stable = 1'b0;
      end
      msack = 1'b1; msdata = (h == 0) ? d0 : d1;
      @(negedge clk);
      msack = 1'b0; msdata = 16'h0000;
      if (h == 0) a0 = addr; else a1 = addr;
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; cmd_tile = '0; cmd_row = '0;
    msack = 1'b0; msdata = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (cmd_ready !== 1'b0) begin failed++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    tests++; if (msreq !== 1'b0) begin failed++; $display("FAIL reset_msreq got %b exp 0", msreq); end
    tests++; if (msaddr !== 17'h0) begin failed++; $display("FAIL reset_msaddr got %h exp 0", msaddr); end
    tests++; if ({out_valid, out_data, out_tile, out_row} !== 20'h0) begin failed++;
      $display("FAIL reset_out got v=%b d=%h t=%h r=%0d exp all 0", out_valid, out_data, out_tile, out_row); end
    rstn = 1'b1;
    #1;
    tests++; if (cmd_ready !== 1'b0) begin failed++; $display("FAIL release_before_edge cmd_ready got %b exp 0", cmd_ready); end
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b1) begin failed++; $display("FAIL release_first_edge cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_basic();
    logic [16:0] a0, a1; int nreq; bit stable, ok;
    run_fetch(8'h12, 3'd5, 16'h1001, 16'h0110, 0, a0, a1, nreq, stable, ok);
    tests++; if (!ok) begin failed++; $display("FAIL basic_handshake got timeout exp completion"); end
    tests++; if (a0 !== 17'h00245) begin failed++; $display("FAIL basic_addr0 got %h exp 00245", a0); end
    tests++; if (a1 !== 17'h00255) begin failed++; $display("FAIL basic_addr1 got %h exp 00255", a1); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_valid_cycle5 got %b exp 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL basic_valid_cycle6 got %b exp 1", out_valid); end
    tests++; if ({out_data, out_tile, out_row} !== {8'h96, 8'h12, 3'd5}) begin failed++;
      $display("FAIL basic_head got d=%h t=%h r=%0d exp d=96 t=12 r=5", out_data, out_tile, out_row); end
    pop_one();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_pop got valid %b exp 0", out_valid); end
  endtask

  task automatic test_noise();
    logic [16:0] a0, a1; int nreq; bit stable, ok;
    run_fetch(8'h3C, 3'd2, 16'hEEEF, 16'hFFFE, 0, a0, a1, nreq, stable, ok);
    @(negedge clk);
    tests++; if ({out_valid, out_data, out_tile, out_row} !== {1'b1, 8'h87, 8'h3C, 3'd2}) begin failed++;
      $display("FAIL noise_head got v=%b d=%h t=%h r=%0d exp v=1 d=87 t=3c r=2", out_valid, out_data, out_tile, out_row); end
    tests++; if (a0 !== 17'h00782 || a1 !== 17'h00792) begin failed++;
      $display("FAIL noise_addr got %h/%h exp 00782/00792", a0, a1); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [16:0] a0, a1; int nreq; bit stable, ok;
    out_ready = 1'b0;
    run_fetch(8'h01, 3'd0, 16'h0001, 16'h1000, 0, a0, a1, nreq, stable, ok);
    @(negedge clk);
    run_fetch(8'h02, 3'd1, 16'h0010, 16'h0100, 0, a0, a1, nreq, stable, ok);
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b0) begin failed++; $display("FAIL bp_full_cmd_ready got %b exp 0", cmd_ready); end
    cmd_tile = 8'h03; cmd_row = 3'd2; cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (msreq !== 1'b0 || cmd_ready !== 1'b0) begin failed++;
      $display("FAIL bp_blocked got msreq=%b cmd_ready=%b exp 0/0", msreq, cmd_ready); end
    tests++; if ({out_data, out_tile, out_row} !== {8'h81, 8'h01, 3'd0}) begin failed++;
      $display("FAIL bp_head0 got d=%h t=%h r=%0d exp d=81 t=01 r=0", out_data, out_tile, out_row); end
    pop_one();
    tests++; if (cmd_ready !== 1'b1) begin failed++; $display("FAIL bp_after_pop cmd_ready got %b exp 1", cmd_ready); end
    tests++; if ({out_data, out_tile, out_row} !== {8'h42, 8'h02, 3'd1}) begin failed++;
      $display("FAIL bp_head1 got d=%h t=%h r=%0d exp d=42 t=02 r=1", out_data, out_tile, out_row); end
    run_fetch(8'h03, 3'd2, 16'h1111, 16'h0000, 0, a0, a1, nreq, stable, ok);
    tests++; if (!ok) begin failed++; $display("FAIL bp_third got timeout exp completion"); end
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b0) begin failed++; $display("FAIL bp_refull cmd_ready got %b exp 0", cmd_ready); end
    tests++; if ({out_data, out_tile} !== {8'h42, 8'h02}) begin failed++;
      $display("FAIL bp_order1 got d=%h t=%h exp d=42 t=02", out_data, out_tile); end
    pop_one();
    tests++; if ({out_valid, out_data, out_tile, out_row} !== {1'b1, 8'hF0, 8'h03, 3'd2}) begin failed++;
      $display("FAIL bp_order2 got v=%b d=%h t=%h r=%0d exp v=1 d=f0 t=03 r=2", out_valid, out_data, out_tile, out_row); end
    pop_one();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_drained got valid %b exp 0", out_valid); end
  endtask

  task automatic test_slow_rom();
    logic [16:0] a0, a1; int nreq; bit stable, ok;
    run_fetch(8'h55, 3'd3, 16'h1010, 16'h0101, 7, a0, a1, nreq, stable, ok);
    tests++; if (nreq !== 2) begin failed++; $display("FAIL slow_msreq_count got %0d exp 2", nreq); end
    tests++; if (stable !== 1'b1) begin failed++; $display("FAIL slow_addr_stable got %b exp 1", stable); end
    tests++; if (a0 !== 17'h00AA3 || a1 !== 17'h00AB3) begin failed++;
      $display("FAIL slow_addr got %h/%h exp 00aa3/00ab3", a0, a1); end
    @(negedge clk);
    tests++; if ({out_valid, out_data, out_tile, out_row} !== {1'b1, 8'h5A, 8'h55, 3'd3}) begin failed++;
      $display("FAIL slow_head got v=%b d=%h t=%h r=%0d exp v=1 d=5a t=55 r=3", out_valid, out_data, out_tile, out_row); end
    pop_one();
    msack = 1'b1; msdata = 16'hFFFF;
    @(negedge clk);
    msack = 1'b0; msdata = 16'h0000;
    @(negedge clk);
    tests++; if ({out_valid, msreq, cmd_ready} !== 3'b001) begin failed++;
      $display("FAIL spurious_ack got valid=%b msreq=%b cmd_ready=%b exp 0/0/1", out_valid, msreq, cmd_ready); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [16:0] a0, a1; int nreq; bit stable, ok;
    out_ready = 1'b0;
    run_fetch(8'h77, 3'd6, 16'h1111, 16'h1111, 0, a0, a1, nreq, stable, ok);
    @(negedge clk);
    cmd_tile = 8'h34; cmd_row = 3'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    msack = 1'b1; msdata = 16'h1111;
    @(negedge clk);
    msack = 1'b0;
    @(negedge clk);
    tests++; if (msaddr !== 17'h00692) begin failed++; $display("FAIL mid_wait1_addr got %h exp 00692", msaddr); end
    rstn = 1'b0;
    #1;
    tests++; if ({cmd_ready, msreq, msaddr} !== 19'h0) begin failed++;
      $display("FAIL mid_reset_ctrl got cmd_ready=%b msreq=%b msaddr=%h exp 0/0/0", cmd_ready, msreq, msaddr); end
    tests++; if ({out_valid, out_data, out_tile, out_row} !== 20'h0) begin failed++;
      $display("FAIL mid_reset_out got v=%b d=%h t=%h r=%0d exp all 0", out_valid, out_data, out_tile, out_row); end
    msack = 1'b1; msdata = 16'h1111;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    msack = 1'b0; msdata = 16'h0000;
    tests++; if ({cmd_ready, msreq, out_valid} !== 3'b100) begin failed++;
      $display("FAIL late_ack got cmd_ready=%b msreq=%b valid=%b exp 1/0/0", cmd_ready, msreq, out_valid); end
    run_fetch(8'hFF, 3'd7, 16'h0011, 16'h1100, 0, a0, a1, nreq, stable, ok);
    tests++; if (a0 !== 17'h01FE7 || a1 !== 17'h01FF7) begin failed++;
      $display("FAIL post_reset_addr got %h/%h exp 01fe7/01ff7", a0, a1); end
    @(negedge clk);
    tests++; if ({out_valid, out_data, out_tile, out_row} !== {1'b1, 8'hC3, 8'hFF, 3'd7}) begin failed++;
      $display("FAIL post_reset_head got v=%b d=%h t=%h r=%0d exp v=1 d=c3 t=ff r=7", out_valid, out_data, out_tile, out_row); end
    pop_one();
  endtask

  task automatic test_push_pop();
    logic [16:0] a0, a1; int nreq; bit stable, ok;
    out_ready = 1'b0;
    run_fetch(8'h10, 3'd1, 16'h0000, 16'h0001, 0, a0, a1, nreq, stable, ok);
    @(negedge clk);
    run_fetch(8'h20, 3'd4, 16'h1000, 16'h0010, 0, a0, a1, nreq, stable, ok);
    tests++; if ({out_valid, out_data, out_tile} !== {1'b1, 8'h08, 8'h10}) begin failed++;
      $display("FAIL pp_before got v=%b d=%h t=%h exp v=1 d=08 t=10", out_valid, out_data, out_tile); end
    pop_one();
    tests++; if ({out_valid, out_data, out_tile, out_row} !== {1'b1, 8'h14, 8'h20, 3'd4}) begin failed++;
      $display("FAIL pp_head got v=%b d=%h t=%h r=%0d exp v=1 d=14 t=20 r=4", out_valid, out_data, out_tile, out_row); end
    tests++; if (cmd_ready !== 1'b1) begin failed++; $display("FAIL pp_count1 cmd_ready got %b exp 1", cmd_ready); end
    pop_one();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL pp_empty got valid %b exp 0", out_valid); end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_basic();
    test_noise();
    test_back_to_back();
    test_slow_rom();
    test_reset_mid_fetch();
    test_push_pop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
